pulse_schedule_ctrl: RTL
========================

Name: pulse_schedule_ctrl

Overview:
- Programmable segment sequencer that drives the step-pulse generator's half-period value and enable.
- Replaces hard-coded hybrid-mode timing with a loadable table of segments. Each segment is a duration in seconds plus a half-period in clocks.
- On start, plays segments 0..num_segs-1 in order using a 1 Hz tick derived from clk, then signals completion.
- Sits between the mode/button logic and the pulse generator; also reports elapsed seconds and the current segment to the display logic.

Parameters:
- CLK_HZ, 100000000, clk cycles per second; one-second tick period.
- SEG_DEPTH, 16, number of table entries (power of 2).
- HP_W, 23, half-period width in clocks.
- DUR_W, 9, segment duration width in seconds; also elapsed_sec width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level or pulse; sampled only in IDLE.
- abort  in  1  stop the schedule immediately.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(SEG_DEPTH)  table entry index.
- cfg_dur  in  DUR_W  segment duration, seconds.
- cfg_hp  in  HP_W  segment half-period, clocks; 0 = rest (no pulses).
- num_segs  in  log2(SEG_DEPTH)+1  segment count to play; values above SEG_DEPTH are clamped to SEG_DEPTH.
- half_period  out  HP_W  value to the pulse generator.
- pulse_en  out  1  pulse generator enable.
- seg_idx  out  log2(SEG_DEPTH)  current segment.
- elapsed_sec  out  DUR_W  whole seconds since start; saturates at all-ones.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; table entries, tick counter and remaining-seconds counter cleared.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - pulse_en=0, half_period=0.
  - start & abort=0 & num_segs!=0 -> LOAD; seg_idx=0, elapsed_sec=0, tick counter=0.
  - start & num_segs==0 -> DONE.
- LOAD (exactly one cycle per segment):
  - Read table[seg_idx].
  - dur==0 -> segment skipped. If it is the last segment -> DONE; else seg_idx+1, remain in LOAD.
  - dur!=0 -> RUN; remaining=dur; half_period=hp; pulse_en=(hp!=0).
  - half_period and pulse_en hold their previous values during LOAD, so the generator sees no glitch between segments.
- RUN:
  - Tick counter counts 0..CLK_HZ-1 and wraps.
  - On wrap: elapsed_sec increments (saturating); remaining decrements.
  - remaining reaches 0: last segment -> DONE; else seg_idx+1 -> LOAD.
  - A segment of d seconds therefore keeps its half_period for exactly d*CLK_HZ RUN cycles.
- DONE (one cycle): pulse_en=0, half_period=0, done=1 -> IDLE. seg_idx and elapsed_sec hold until the next start.
- Abort:
  - abort in LOAD or RUN -> IDLE next cycle; pulse_en=0, half_period=0; no done.
  - abort has priority over every other transition, including a simultaneous segment end.
- start while busy or in DONE is ignored; no restart.
- Table writes:
  - Accepted only in IDLE; written at the clock edge.
  - cfg_we in any other state: write dropped, cfg_err=1 for one cycle.
  - A write and a start in the same IDLE cycle: the write lands first, so the new entry is used.
- num_segs is sampled when start is accepted; later changes are ignored until the next IDLE.

Test Plan:
- CLK_HZ=10; table {0:(2,5), 1:(1,3), 2:(1,7)}; num_segs=3; start pulse -> half_period=5 for 20 RUN cycles, then 1 LOAD cycle (still 5), 3 for 10, LOAD, 7 for 10; done pulses once; elapsed_sec=4; pulse_en never drops before DONE.
- Table {0:(1,4), 1:(0,9), 2:(1,6)}, num_segs=3 -> half_period goes 4 -> 6; 9 never appears; LOAD spans 2 cycles; elapsed_sec=2.
- Entry hp=0, dur=1 -> pulse_en=0 for 10 cycles while busy=1; the following segment re-enables.
- abort 5 cycles into segment 1 -> next cycle IDLE, pulse_en=0, busy=0, done never asserts; a new start reruns from seg_idx=0.
- cfg_we to addr 0 during RUN -> cfg_err one cycle; after completion entry 0 reads unchanged. num_segs=0 with start -> DONE next cycle, done=1, pulse_en stays 0. num_segs=20 -> plays 16 entries.
- rst_n low mid-RUN (asynchronous, not clock-aligned) -> outputs 0 immediately; table cleared; after release, start with num_segs=1 skips the dur=0 entry and goes to DONE.

Source files
------------

// File: rtl/pulse_schedule_ctrl_if.sv
// rtl/pulse_schedule_ctrl_if.sv - control, table-config and output bundle of the pulse schedule sequencer
interface pulse_schedule_ctrl_if #(
  parameter int SEG_DEPTH = 16,
  parameter int HP_W      = 23,
  parameter int DUR_W     = 9
);
  localparam int AW = $clog2(SEG_DEPTH);

  logic             start;
  logic             abort;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [DUR_W-1:0] cfg_dur;
  logic [HP_W-1:0]  cfg_hp;
  logic [AW:0]      num_segs;
  logic [HP_W-1:0]  half_period;
  logic             pulse_en;
  logic [AW-1:0]    seg_idx;
  logic [DUR_W-1:0] elapsed_sec;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output start, abort, cfg_we, cfg_addr, cfg_dur, cfg_hp, num_segs,
    input  half_period, pulse_en, seg_idx, elapsed_sec, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_we, cfg_addr, cfg_dur, cfg_hp, num_segs,
    output half_period, pulse_en, seg_idx, elapsed_sec, busy, done, cfg_err
  );
endinterface

// File: rtl/pulse_schedule_ctrl.sv
// rtl/pulse_schedule_ctrl.sv - segment-table sequencer driving the step-pulse generator
module pulse_schedule_ctrl #(
  parameter int CLK_HZ    = 100000000,
  parameter int SEG_DEPTH = 16,
  parameter int HP_W      = 23,
  parameter int DUR_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_schedule_ctrl_if.slave bus
);
  localparam int AW = $clog2(SEG_DEPTH);
  localparam int TW = $clog2(CLK_HZ + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [AW:0]   SEGS_MAX  = (AW+1)'(SEG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t           r_state, w_next_state;
  logic [DUR_W-1:0] r_tab_dur [SEG_DEPTH];
  logic [HP_W-1:0]  r_tab_hp  [SEG_DEPTH];
  logic [TW-1:0]    r_tick, w_tick;
  logic [DUR_W-1:0] r_remain, w_remain;
  logic [AW-1:0]    r_seg_idx, w_seg_idx;
  logic [AW-1:0]    r_last_idx, w_last_idx;
  logic [DUR_W-1:0] r_elapsed, w_elapsed;
  logic [HP_W-1:0]  r_half_period, w_half_period;
  logic             r_pulse_en, w_pulse_en;
  logic             r_busy, r_done, r_cfg_err;
  logic [AW:0]      w_segs_clamped;
  logic [DUR_W-1:0] w_cur_dur;
  logic [HP_W-1:0]  w_cur_hp;
  logic             w_is_last;

  assign w_segs_clamped = (bus.num_segs > SEGS_MAX) ? SEGS_MAX : bus.num_segs;
  assign w_cur_dur      = r_tab_dur[r_seg_idx];
  assign w_cur_hp       = r_tab_hp[r_seg_idx];
  assign w_is_last      = (r_seg_idx == r_last_idx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and next-value logic; abort is tested first so it beats any segment end
  always_comb begin
    w_next_state  = r_state;
    w_tick        = r_tick;
    w_remain      = r_remain;
    w_seg_idx     = r_seg_idx;
    w_last_idx    = r_last_idx;
    w_elapsed     = r_elapsed;
    w_half_period = r_half_period;
    w_pulse_en    = r_pulse_en;
    case (r_state)
      ST_IDLE: begin
        w_half_period = '0;
        w_pulse_en    = 1'b0;
        if (bus.start) begin
          w_seg_idx = '0;
          w_elapsed = '0;
          w_tick    = '0;
          if (bus.num_segs == '0) begin
            w_next_state = ST_DONE;
          end else if (!bus.abort) begin
            w_next_state = ST_LOAD;
            w_last_idx   = AW'(w_segs_clamped - (AW+1)'(1));
          end
        end
      end
      ST_LOAD: begin
        // half_period/pulse_en keep last segment's values so the generator sees no gap
        if (bus.abort) begin
          w_next_state  = ST_IDLE;
          w_half_period = '0;
          w_pulse_en    = 1'b0;
        end else if (w_cur_dur == '0) begin
          if (w_is_last) begin
            w_next_state  = ST_DONE;
            w_half_period = '0;
            w_pulse_en    = 1'b0;
          end else begin
            w_seg_idx = r_seg_idx + AW'(1);
          end
        end else begin
          w_next_state  = ST_RUN;
          w_remain      = w_cur_dur;
          w_half_period = w_cur_hp;
          w_pulse_en    = (w_cur_hp != '0);
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_next_state  = ST_IDLE;
          w_half_period = '0;
          w_pulse_en    = 1'b0;
        end else if (r_tick == TICK_LAST) begin
          w_tick    = '0;
          w_remain  = r_remain - DUR_W'(1);
          w_elapsed = (r_elapsed == '1) ? r_elapsed : r_elapsed + DUR_W'(1);
          if (r_remain == DUR_W'(1)) begin
            if (w_is_last) begin
              w_next_state  = ST_DONE;
              w_half_period = '0;
              w_pulse_en    = 1'b0;
            end else begin
              w_next_state = ST_LOAD;
              w_seg_idx    = r_seg_idx + AW'(1);
            end
          end
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      ST_DONE: begin
        w_next_state  = ST_IDLE;
        w_half_period = '0;
        w_pulse_en    = 1'b0;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath, table storage and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEG_DEPTH; i++) begin
        r_tab_dur[i] <= '0;
        r_tab_hp[i]  <= '0;
      end
      r_tick        <= '0;
      r_remain      <= '0;
      r_seg_idx     <= '0;
      r_last_idx    <= '0;
      r_elapsed     <= '0;
      r_half_period <= '0;
      r_pulse_en    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      if (bus.cfg_we && r_state == ST_IDLE) begin
        r_tab_dur[bus.cfg_addr] <= bus.cfg_dur;
        r_tab_hp[bus.cfg_addr]  <= bus.cfg_hp;
      end
      r_tick        <= w_tick;
      r_remain      <= w_remain;
      r_seg_idx     <= w_seg_idx;
      r_last_idx    <= w_last_idx;
      r_elapsed     <= w_elapsed;
      r_half_period <= w_half_period;
      r_pulse_en    <= w_pulse_en;
      r_busy        <= (w_next_state == ST_LOAD) || (w_next_state == ST_RUN);
      r_done        <= (w_next_state == ST_DONE);
      r_cfg_err     <= bus.cfg_we && (r_state != ST_IDLE);
    end
  end

  assign bus.half_period = r_half_period;
  assign bus.pulse_en    = r_pulse_en;
  assign bus.seg_idx     = r_seg_idx;
  assign bus.elapsed_sec = r_elapsed;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.cfg_err     = r_cfg_err;
endmodule
